pid_seq: RTL and testbench

PID_SEQ -- requirements
Module: pid_seq

---
 rtl/pid_seq.sv | 129 ++++++++++++
 tb/tb_pid_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_seq.sv
// ============================================================================
// Module   : pid_seq
// Purpose  : Forward-move sequencer: ramps frwrd up, cruises, ramps down after
//            2*num_sqrs line crossings. Macro RAMP_DN_2X_EN doubles ramp-down.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pid_seq #(
    parameter logic [9:0] MAX_SPD = 10'h2A0,
    parameter logic [9:0] INC     = 10'h010
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       strt_mv,
    input  logic [2:0] num_sqrs,
    input  logic       cntrIR,
    input  logic       err_vld,
    output logic [9:0] frwrd,
    output logic       moving,
    output logic       busy,
    output logic       mv_done
);

`ifdef RAMP_DN_2X_EN
    localparam logic [10:0] c_DEC = {INC, 1'b0};
`else
    localparam logic [10:0] c_DEC = {1'b0, INC};
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RAMP_UP = 3'd1,
        CRUISE  = 3'd2,
        RAMP_DN = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_cntr_q;
    logic [3:0]  r_cnt;
    logic [3:0]  r_tgt;

    logic        w_rise;
    logic        w_hit;
    logic        w_active;
    logic [10:0] w_sum;
    logic [9:0]  w_up;
    logic [9:0]  w_dn;

    assign w_rise   = cntrIR & ~r_cntr_q;
    assign w_hit    = (r_cnt == r_tgt);
    assign w_active = (r_state == RAMP_UP) || (r_state == CRUISE) || (r_state == RAMP_DN);

    // Widened sum so the clamp works even when INC overshoots the top of range
    assign w_sum = {1'b0, frwrd} + {1'b0, INC};
    assign w_up  = (w_sum >= {1'b0, MAX_SPD}) ? MAX_SPD : w_sum[9:0];
    assign w_dn  = ({1'b0, frwrd} >= c_DEC) ? (frwrd - c_DEC[9:0]) : 10'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cntr_q <= 1'b0;
            r_cnt    <= 4'd0;
            r_tgt    <= 4'd0;
            frwrd    <= 10'd0;
            moving   <= 1'b0;
            busy     <= 1'b0;
            mv_done  <= 1'b0;
        end else begin
            r_cntr_q <= cntrIR;
            if (w_active && w_rise && !w_hit)
                r_cnt <= r_cnt + 4'd1;

            case (r_state)
                IDLE: begin
                    if (strt_mv) begin
                        busy <= 1'b1;
                        if (num_sqrs != 3'd0) begin
                            r_tgt   <= {num_sqrs, 1'b0};
                            r_cnt   <= 4'd0;
                            r_state <= RAMP_UP;
                            moving  <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            mv_done <= 1'b1;
                        end
                    end
                end
                RAMP_UP: begin
                    if (err_vld)
                        frwrd <= w_up;
                    // Reaching the crossing target wins over reaching cruise speed
                    if (w_hit)
                        r_state <= RAMP_DN;
                    else if ((err_vld && (w_up == MAX_SPD)) || (frwrd == MAX_SPD))
                        r_state <= CRUISE;
                end
                CRUISE: begin
                    if (w_hit)
                        r_state <= RAMP_DN;
                end
                RAMP_DN: begin
                    if (err_vld)
                        frwrd <= w_dn;
                    if ((err_vld && (w_dn == 10'd0)) || (frwrd == 10'd0)) begin
                        r_state <= DONE;
                        moving  <= 1'b0;
                        mv_done <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    mv_done <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    moving  <= 1'b0;
                    busy    <= 1'b0;
                    mv_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pid_seq.sv
// ============================================================================
// Module   : tb_pid_seq
// Purpose  : Self-checking bench for pid_seq (vector table, directed moves,
//            randomized traffic against a behavioural model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pid_seq;

    localparam int MAXV = 'h2A0;
    localparam int INCV = 'h010;
`ifdef RAMP_DN_2X_EN
    localparam int DEC = 2 * INCV;
`else
    localparam int DEC = INCV;
`endif

    localparam int S_IDLE = 0, S_UP = 1, S_CR = 2, S_DN = 3, S_DONE = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       strt_mv = 1'b0;
    logic [2:0] num_sqrs = 3'd0;
    logic       cntrIR = 1'b0;
    logic       err_vld = 1'b0;
    logic [9:0] frwrd;
    logic       moving, busy, mv_done;

    pid_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .strt_mv  (strt_mv),
        .num_sqrs (num_sqrs),
        .cntrIR   (cntrIR),
        .err_vld  (err_vld),
        .frwrd    (frwrd),
        .moving   (moving),
        .busy     (busy),
        .mv_done  (mv_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       s;
        logic [2:0] ns;
        logic       c;
        logic       e;
        int         f;
        logic       m;
        logic       b;
        logic       d;
    } vec_t;
    vec_t tbl[$];

    // behavioural model state
    int   m_st, m_f, m_cnt, m_tgt;
    logic m_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add(input logic s, input logic [2:0] ns, input logic c, input logic e,
                       input int f, input logic m, input logic b, input logic d);
        vec_t v;
        v.s = s; v.ns = ns; v.c = c; v.e = e;
        v.f = f; v.m = m; v.b = b; v.d = d;
        tbl.push_back(v);
    endtask

    task automatic model_reset();
        m_st = S_IDLE; m_f = 0; m_cnt = 0; m_tgt = 0; m_prev = 1'b0;
    endtask

    // One clock of the sequencer, described by its behavioural rules
    task automatic model_step(input logic s, input logic [2:0] ns, input logic c, input logic e);
        int  st0;
        int  old_cnt;
        bit  rise;
        st0     = m_st;
        old_cnt = m_cnt;
        rise    = c && !m_prev;
        case (m_st)
            S_IDLE: if (s) begin
                if (ns != 0) begin
                    m_tgt = 2 * int'(ns);
                    m_cnt = 0;
                    m_st  = S_UP;
                end else begin
                    m_st = S_DONE;
                end
            end
            S_UP: begin
                if (e) m_f = (m_f + INCV > MAXV) ? MAXV : m_f + INCV;
                if (old_cnt == m_tgt) m_st = S_DN;
                else if (m_f == MAXV) m_st = S_CR;
            end
            S_CR: if (old_cnt == m_tgt) m_st = S_DN;
            S_DN: begin
                if (e) m_f = (m_f > DEC) ? m_f - DEC : 0;
                if (m_f == 0) m_st = S_DONE;
            end
            default: m_st = S_IDLE;
        endcase
        if ((st0 == S_UP || st0 == S_CR || st0 == S_DN) && rise && old_cnt < m_tgt)
            m_cnt = old_cnt + 1;
        m_prev = c;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   ticks;
        bit   seen;
        bit   mono_ok;
        int   prev_f;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("rst_frwrd", 32'(frwrd), 0);
        chk("rst_moving", 32'(moving), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mv_done", 32'(mv_done), 0);
        rst_n = 1'b1;

        // ---------------- vector table ----------------
        add(0, 0, 0, 0, 'h000, 0, 0, 0);
        add(1, 0, 0, 0, 'h000, 0, 1, 1);   // zero squares: straight to DONE
        add(0, 0, 0, 0, 'h000, 0, 0, 0);
        add(0, 0, 0, 1, 'h000, 0, 0, 0);   // err_vld in IDLE ignored
        add(1, 1, 0, 0, 'h000, 1, 1, 0);
        add(1, 3, 0, 1, 'h010, 1, 1, 0);   // strt_mv while busy ignored
        add(0, 0, 0, 1, 'h020, 1, 1, 0);
        add(0, 0, 1, 0, 'h020, 1, 1, 0);
        add(0, 0, 0, 1, 'h030, 1, 1, 0);
        add(0, 0, 1, 1, 'h040, 1, 1, 0);   // tick and second crossing together
        add(0, 0, 0, 0, 'h040, 1, 1, 0);
        begin
            int v;
            bit first;
            v = 'h040;
            first = 1'b1;
            while (v > 0) begin
                v = (v > DEC) ? v - DEC : 0;
                add(0, 0, first, 1, v, v != 0, 1, v == 0);
                first = 1'b0;
            end
        end
        add(0, 0, 0, 0, 'h000, 0, 0, 0);

        foreach (tbl[i]) begin
            strt_mv = tbl[i].s; num_sqrs = tbl[i].ns; cntrIR = tbl[i].c; err_vld = tbl[i].e;
            tick();
            chk($sformatf("tbl%0d_frwrd", i), 32'(frwrd), 32'(tbl[i].f));
            chk($sformatf("tbl%0d_moving", i), 32'(moving), 32'(tbl[i].m));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].b));
            chk($sformatf("tbl%0d_mv_done", i), 32'(mv_done), 32'(tbl[i].d));
        end
        strt_mv = 0; num_sqrs = 0; cntrIR = 0; err_vld = 0;

        // ---------------- async reset mid ramp-up ----------------
        strt_mv = 1; num_sqrs = 3'd2;
        tick();
        strt_mv = 0;
        repeat (8) begin err_vld = 1; tick(); end
        err_vld = 0;
        chk("pre_rst_frwrd", 32'(frwrd), 'h080);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_frwrd", 32'(frwrd), 0);
        chk("async_rst_moving", 32'(moving), 0);
        chk("async_rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1; strt_mv = 1; num_sqrs = 3'd1;
        tick();
        strt_mv = 0; num_sqrs = 0;
        chk("post_rst_accept_busy", 32'(busy), 1);
        chk("post_rst_accept_moving", 32'(moving), 1);

        // ---------------- full ramp to cruise and back ----------------
        for (int i = 0; i < 42; i++) begin
            err_vld = 1; tick(); err_vld = 0;
            repeat (3) tick();
        end
        chk("cruise_frwrd", 32'(frwrd), MAXV);
        chk("cruise_moving", 32'(moving), 1);
        strt_mv = 1; num_sqrs = 3'd3; tick(); strt_mv = 0; num_sqrs = 0;
        err_vld = 1; tick(); err_vld = 0; tick();
        chk("cruise_hold_frwrd", 32'(frwrd), MAXV);
        repeat (2) begin cntrIR = 1; tick(); cntrIR = 0; tick(); end
        ticks = 0; seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            err_vld = 1; tick(); err_vld = 0;
            ticks++;
            if (mv_done) seen = 1;
            else repeat (3) tick();
        end
        chk("rampdn_done_seen", 32'(seen), 1);
        chk("rampdn_ticks", 32'(ticks), MAXV / DEC);
        chk("rampdn_frwrd_zero", 32'(frwrd), 0);
        tick();
        chk("rampdn_single_pulse", 32'(mv_done), 0);
        chk("rampdn_idle_busy", 32'(busy), 0);

        // ---------------- short move, extra crossing in ramp-down ----------------
        strt_mv = 1; num_sqrs = 3'd1; tick(); strt_mv = 0; num_sqrs = 0;
        repeat (5) begin err_vld = 1; tick(); err_vld = 0; tick(); end
        chk("short_frwrd", 32'(frwrd), 'h050);
        repeat (2) begin cntrIR = 1; tick(); cntrIR = 0; tick(); end
        cntrIR = 1; tick(); cntrIR = 0;
        ticks = 0; seen = 0; mono_ok = 1;
        for (int i = 0; i < 50 && !seen; i++) begin
            prev_f = int'(frwrd);
            err_vld = 1; tick(); err_vld = 0;
            ticks++;
            if (int'(frwrd) > prev_f) mono_ok = 0;
            if (mv_done) seen = 1;
            else tick();
        end
        chk("short_done_seen", 32'(seen), 1);
        chk("short_ticks", 32'(ticks), ('h050 + DEC - 1) / DEC);
        chk("short_no_underflow", 32'(mono_ok), 1);
        tick();
        chk("short_single_pulse", 32'(mv_done), 0);

        // ---------------- randomized traffic vs model ----------------
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 2000; i++) begin
            strt_mv  = ($urandom_range(0, 19) == 0);
            num_sqrs = 3'($urandom_range(0, 7));
            err_vld  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) cntrIR = ~cntrIR;
            model_step(strt_mv, num_sqrs, cntrIR, err_vld);
            tick();
            chk("rnd_frwrd", 32'(frwrd), 32'(m_f));
            chk("rnd_moving", 32'(moving), 32'(m_st == S_UP || m_st == S_CR || m_st == S_DN));
            chk("rnd_busy", 32'(busy), 32'(m_st != S_IDLE));
            chk("rnd_mv_done", 32'(mv_done), 32'(m_st == S_DONE));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
